otter_pipe_ctrl: RTL and testbench

Central pipeline controller for the 5-stage pipelined OTTER core; sole owner of the per-stage valid bits.
Generates per-stage stall and bubble controls, EX-stage operand forwarding selects, and sequences interrupt entry by draining the pipeline.
Sits beside the IF/DE/EX/MEM/WB registers, consuming decoded register addresses and control flags from each stage.

---
 rtl/otter_pkg.sv | 32 +++
 rtl/otter_fwd_unit.sv | 26 ++
 rtl/otter_pipe_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_otter_pipe_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared types for the OTTER pipeline control slice
package otter_pkg;

  // RV32I major opcodes seen by the decode stage
  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_SYSTEM = 7'b1110011
  } opcode_t;

  // EX operand source: register file, EX/MEM ALU result, MEM/WB write data
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  // Interrupt sequencing: normal issue, pipeline drain, one-cycle trap entry
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    TRAP  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/otter_fwd_unit.sv
// rtl/otter_fwd_unit.sv - forwarding select for one EX source operand
module otter_fwd_unit
  import otter_pkg::*;
(
  input  logic [4:0] exRs,
  input  logic       exRsUsed,
  input  logic       vMem,
  input  logic       memRegWrite,
  input  logic [4:0] memRd,
  input  logic       vWb,
  input  logic       wbRegWrite,
  input  logic [4:0] wbRd,
  output logic [1:0] fwdSel
);

  // MEM is younger than WB, so its result wins; x0 is never forwarded
  always_comb begin
    fwdSel = FWD_RF;
    if (exRsUsed && vMem && memRegWrite && (memRd == exRs) && (memRd != 5'd0)) begin
      fwdSel = FWD_MEM;
    end else if (exRsUsed && vWb && wbRegWrite && (wbRd == exRs) && (wbRd != 5'd0)) begin
      fwdSel = FWD_WB;
    end
  end

endmodule

// File: rtl/otter_pipe_ctrl.sv
// rtl/otter_pipe_ctrl.sv - OTTER pipeline controller: valids, stalls, forwarding, interrupt drain
module otter_pipe_ctrl
  import otter_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             INTR,
  input  logic             intr_en,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic             de_rs1_used,
  input  logic             de_rs2_used,
  input  logic [XLEN-1:0]  de_pc,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic             ex_rs1_used,
  input  logic             ex_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             stall_pc,
  output logic             stall_if,
  output logic             stall_de,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             v_de,
  output logic             v_ex,
  output logic             v_mem,
  output logic             v_wb,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             intr_take,
  output logic [XLEN-1:0]  intr_epc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  ctrl_state_t state;

  logic memWait;
  logic loadUse;
  logic redir;
  logic intrReq;
  logic drainDone;
  logic nDe;
  logic nEx;
  logic nMem;
  logic nWb;

  // Hazard detection; a load writing x0 never creates a dependency.
  // ex_reg_write is implied by ex_mem_read for loads, so it is not part of the test.
  assign memWait = v_mem & mem_access & ~dmem_ready;
  assign loadUse = v_ex & ex_mem_read & (ex_rd != 5'd0) & v_de &
                   ((de_rs1_used & (de_rs1 == ex_rd)) | (de_rs2_used & (de_rs2 == ex_rd)));
  assign redir   = v_ex & ex_redirect;

  // The interrupt is only accepted on a clean cycle so the DE PC is a valid return point
  assign intrReq   = INTR & intr_en & v_de & ~memWait & ~redir & ~loadUse;
  assign drainDone = ~v_ex & ~v_mem & ~v_wb & ~memWait;

  // Stall outputs and next-cycle valid bits, by hazard priority then FSM overrides
  always_comb begin
    stall_pc  = 1'b0;
    stall_if  = 1'b0;
    stall_de  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    nDe       = v_de;
    nEx       = v_ex;
    nMem      = v_mem;
    nWb       = v_wb;
    if (memWait) begin
      stall_pc  = 1'b1;
      stall_if  = 1'b1;
      stall_de  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      nWb       = 1'b0;
    end else if (redir) begin
      nDe  = 1'b0;
      nEx  = 1'b0;
      nMem = 1'b1;
      nWb  = v_mem;
    end else if (loadUse) begin
      stall_pc = 1'b1;
      stall_if = 1'b1;
      stall_de = 1'b1;
      nEx      = 1'b0;
      nMem     = v_ex;
      nWb      = v_mem;
    end else begin
      nDe  = (state == RUN);
      nEx  = v_de;
      nMem = v_ex;
      nWb  = v_mem;
    end
    case (state)
      RUN: begin
        if (intrReq) nDe = 1'b0;
      end
      DRAIN: begin
        stall_pc = 1'b1;
        stall_if = 1'b1;
        nDe      = 1'b0;
      end
      TRAP: begin
        stall_pc = 1'b0;
        nDe      = 1'b0;
      end
      default: begin
        nDe = 1'b0;
      end
    endcase
  end

  // Valid bits, counters and interrupt FSM; reset overrides everything including a drain
  always_ff @(posedge CLK) begin
    if (RESET) begin
      v_de         <= 1'b0;
      v_ex         <= 1'b0;
      v_mem        <= 1'b0;
      v_wb         <= 1'b0;
      state        <= RUN;
      intr_take    <= 1'b0;
      intr_epc     <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      v_de      <= nDe;
      v_ex      <= nEx;
      v_mem     <= nMem;
      v_wb      <= nWb;
      intr_take <= 1'b0;
      if (stall_pc) stall_cycles <= stall_cycles + CNT_W'(1);
      if (redir && !memWait) flush_count <= flush_count + CNT_W'(v_de ? 2'd2 : 2'd1);
      case (state)
        RUN: begin
          if (intrReq) begin
            state    <= DRAIN;
            intr_epc <= de_pc;
          end
        end
        DRAIN: begin
          if (redir && !memWait) intr_epc <= redirect_target;
          if (drainDone) begin
            state     <= TRAP;
            intr_take <= 1'b1;
          end
        end
        TRAP: begin
          state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  otter_fwd_unit u_fwd_a (
    .exRs        (ex_rs1),
    .exRsUsed    (ex_rs1_used),
    .vMem        (v_mem),
    .memRegWrite (mem_reg_write),
    .memRd       (mem_rd),
    .vWb         (v_wb),
    .wbRegWrite  (wb_reg_write),
    .wbRd        (wb_rd),
    .fwdSel      (fwd_a_sel)
  );

  otter_fwd_unit u_fwd_b (
    .exRs        (ex_rs2),
    .exRsUsed    (ex_rs2_used),
    .vMem        (v_mem),
    .memRegWrite (mem_reg_write),
    .memRd       (mem_rd),
    .vWb         (v_wb),
    .wbRegWrite  (wb_reg_write),
    .wbRd        (wb_rd),
    .fwdSel      (fwd_b_sel)
  );

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// tb/tb_otter_pipe_ctrl.sv - directed self-checking bench for otter_pipe_ctrl
module tb_otter_pipe_ctrl;
  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic             CLK;
  logic             RESET;
  logic             INTR;
  logic             intr_en;
  logic [4:0]       de_rs1, de_rs2;
  logic             de_rs1_used, de_rs2_used;
  logic [XLEN-1:0]  de_pc;
  logic [4:0]       ex_rs1, ex_rs2;
  logic             ex_rs1_used, ex_rs2_used;
  logic [4:0]       ex_rd;
  logic             ex_reg_write, ex_mem_read, ex_redirect;
  logic [XLEN-1:0]  redirect_target;
  logic [4:0]       mem_rd;
  logic             mem_reg_write, mem_access, dmem_ready;
  logic [4:0]       wb_rd;
  logic             wb_reg_write;
  logic             stall_pc, stall_if, stall_de, stall_ex, stall_mem;
  logic             v_de, v_ex, v_mem, v_wb;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             intr_take;
  logic [XLEN-1:0]  intr_epc;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int nCompared   = 0;
  int nMismatched = 0;

  otter_pipe_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .INTR(INTR), .intr_en(intr_en),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .de_pc(de_pc),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_redirect(ex_redirect), .redirect_target(redirect_target),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .stall_pc(stall_pc), .stall_if(stall_if), .stall_de(stall_de), .stall_ex(stall_ex),
    .stall_mem(stall_mem),
    .v_de(v_de), .v_ex(v_ex), .v_mem(v_mem), .v_wb(v_wb),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .intr_take(intr_take), .intr_epc(intr_epc),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic setIdle;
    INTR = 0; intr_en = 0;
    de_rs1 = 0; de_rs2 = 0; de_rs1_used = 0; de_rs2_used = 0; de_pc = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rs1_used = 0; ex_rs2_used = 0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_redirect = 0; redirect_target = 0;
    mem_rd = 0; mem_reg_write = 0; mem_access = 0; dmem_ready = 1;
    wb_rd = 0; wb_reg_write = 0;
  endtask

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkValid(input string tag, input logic [3:0] exp);
    checkVal(tag, {v_de, v_ex, v_mem, v_wb}, exp);
  endtask

  initial begin
    RESET = 1;
    setIdle();
    tick();
    tick();
    checkValid("rst_valid", 4'b0000);
    checkVal("rst_take", intr_take, 0);
    checkVal("rst_epc", intr_epc, 0);
    checkVal("rst_scnt", stall_cycles, 0);
    checkVal("rst_fcnt", flush_count, 0);
    RESET = 0;

    tick();
    checkValid("fill1", 4'b1000);
    tick(); tick(); tick();
    checkValid("fill4", 4'b1111);

    // lw x5 in EX, add x6,x5,x1 in DE
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5;
    de_rs1 = 5; de_rs1_used = 1; de_rs2 = 1; de_rs2_used = 1;
    #1;
    checkVal("lu_stalls", {stall_pc, stall_if, stall_de, stall_ex, stall_mem}, 5'b11100);
    tick();
    checkValid("lu_bubble", 4'b1011);
    checkVal("lu_scnt", stall_cycles, 1);
    mem_rd = 5; mem_reg_write = 1; mem_access = 1;
    #1;
    checkVal("lu_once", stall_pc, 0);
    tick();
    checkValid("lu_adv", 4'b1101);
    ex_mem_read = 0; ex_rd = 6; ex_rs1 = 5; ex_rs1_used = 1; ex_rs2 = 1; ex_rs2_used = 1;
    wb_rd = 5; wb_reg_write = 1;
    #1;
    checkVal("lu_fwd_a", fwd_a_sel, 2);
    checkVal("lu_fwd_b", fwd_b_sel, 0);
    checkVal("lu_scnt2", stall_cycles, 1);
    setIdle();
    tick(); tick();
    checkValid("refill", 4'b1111);

    // add x3,x1,x2 in MEM; sub x4,x3,x3 in EX
    ex_rs1 = 3; ex_rs2 = 3; ex_rs1_used = 1; ex_rs2_used = 1;
    mem_rd = 3; mem_reg_write = 1; wb_rd = 3; wb_reg_write = 1;
    #1;
    checkVal("fwd_mem_a", fwd_a_sel, 1);
    checkVal("fwd_mem_b", fwd_b_sel, 1);
    checkVal("fwd_nostall", stall_pc, 0);
    mem_rd = 0; wb_rd = 0;
    #1;
    checkVal("fwd_x0_a", fwd_a_sel, 0);
    checkVal("fwd_x0_b", fwd_b_sel, 0);
    wb_rd = 3;
    #1;
    checkVal("fwd_wb_a", fwd_a_sel, 2);
    ex_rs2_used = 0;
    #1;
    checkVal("fwd_unused_b", fwd_b_sel, 0);
    setIdle();

    // taken beq in EX with a valid DE instruction
    ex_redirect = 1; redirect_target = 32'h80;
    #1;
    checkVal("redir_nostall", stall_pc, 0);
    tick();
    checkValid("redir_flush", 4'b0011);
    checkVal("redir_fcnt", flush_count, 2);
    checkVal("redir_scnt", stall_cycles, 1);
    ex_redirect = 0;
    tick();
    checkValid("redir_after", 4'b1001);
    tick(); tick(); tick();
    checkValid("redir_refill", 4'b1111);

    // sw in MEM, dmem_ready low for 3 cycles
    mem_access = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkVal($sformatf("mw_stalls%0d", i), {stall_pc, stall_if, stall_de, stall_ex, stall_mem}, 5'b11111);
      tick();
      checkValid($sformatf("mw_valid%0d", i), 4'b1110);
    end
    checkVal("mw_scnt", stall_cycles, 4);
    dmem_ready = 1;
    #1;
    checkVal("mw_release", stall_mem, 0);
    tick();
    checkValid("mw_adv", 4'b1111);
    checkVal("mw_scnt2", stall_cycles, 4);
    setIdle();

    // interrupt with a jal at 0x100 in DE that redirects to 0x200 during the drain
    INTR = 1; intr_en = 1; de_pc = 32'h100;
    #1;
    checkVal("int_entry_stall", stall_pc, 0);
    tick();
    checkValid("int_drain0", 4'b0111);
    checkVal("int_epc0", intr_epc, 32'h100);
    checkVal("int_take0", intr_take, 0);
    INTR = 0; ex_redirect = 1; redirect_target = 32'h200;
    #1;
    checkVal("int_drain_stall", {stall_pc, stall_if}, 2'b11);
    tick();
    checkValid("int_drain1", 4'b0011);
    checkVal("int_epc1", intr_epc, 32'h200);
    checkVal("int_fcnt", flush_count, 3);
    ex_redirect = 0;
    tick();
    checkValid("int_drain2", 4'b0001);
    checkVal("int_take2", intr_take, 0);
    tick();
    checkValid("int_drain3", 4'b0000);
    checkVal("int_take3", intr_take, 0);
    tick();
    checkVal("int_take_pulse", intr_take, 1);
    checkVal("int_trap_pc", stall_pc, 0);
    checkVal("int_scnt", stall_cycles, 8);
    tick();
    checkVal("int_take_end", intr_take, 0);
    checkValid("int_run0", 4'b0000);
    checkVal("int_epc_hold", intr_epc, 32'h200);
    tick();
    checkValid("int_run1", 4'b1000);

    // reset while draining
    INTR = 1; intr_en = 1; de_pc = 32'h300;
    tick();
    checkValid("rd_drain", 4'b0100);
    checkVal("rd_epc", intr_epc, 32'h300);
    INTR = 0; RESET = 1;
    tick();
    RESET = 0;
    checkValid("rd_valid", 4'b0000);
    checkVal("rd_epc0", intr_epc, 0);
    checkVal("rd_scnt", stall_cycles, 0);
    checkVal("rd_fcnt", flush_count, 0);
    checkVal("rd_take", intr_take, 0);
    tick();
    checkValid("rd_run", 4'b1000);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkVal($sformatf("rd_notake%0d", i), intr_take, 0);
    end
    checkValid("rd_fill", 4'b1111);

    // interrupt masked
    INTR = 1; intr_en = 0;
    tick();
    checkValid("mask_valid", 4'b1111);
    checkVal("mask_epc", intr_epc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
